// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial add/subtract controller:
// FSM state encoding and the op input encoding.
package serial_add_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/serial_add_ctrl_bit_adder_cell.sv
// Single 1-bit full adder; the controller reuses this one cell for every bit position.
module bit_adder_cell (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder/subtractor: one full-adder cell, LSB first, one bit per clock.
// Subtract is a + ~b + 1, so cout = 1 means no borrow.
// Optional feature: define SERIAL_ADD_OVF_EN to keep the MSB carry-in register
// and report signed overflow; otherwise ovf is tied to 0.
module serial_add_ctrl
   import serial_add_ctrl_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] ALL_BITS = CNT_W'(WIDTH);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] res;
   logic             carry;
   logic             cell_s;
   logic             cell_cout;

`ifdef SERIAL_ADD_OVF_EN
   logic             msb_cin;
   logic             ovf_q;

   assign ovf = ovf_q;
`else
   assign ovf = 1'b0;
`endif

   bit_adder_cell u_cell (
      .a    (a_sh[0]),
      .b    (b_sh[0]),
      .cin  (carry),
      .s    (cell_s),
      .cout (cell_cout)
   );

   // Controller: accepts work in IDLE/DONE, shifts one bit per RUN cycle, then one
   // extra RUN cycle (counter == WIDTH) publishes the result into the output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         carry <= 1'b0;
         a_sh  <= '0;
         b_sh  <= '0;
         res   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         sum   <= '0;
         cout  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
         msb_cin <= 1'b0;
         ovf_q   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE, DONE: begin
               done <= 1'b0;
               if (start) begin
                  a_sh  <= a;
                  b_sh  <= (op == OP_ADD) ? b : ~b;
                  carry <= (op == OP_ADD) ? cin : 1'b1;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= RUN;
               end else begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            RUN: begin
               if (cnt == ALL_BITS) begin
                  sum   <= res;
                  cout  <= carry;
`ifdef SERIAL_ADD_OVF_EN
                  ovf_q <= msb_cin ^ carry;
`endif
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  res   <= {cell_s, res[WIDTH-1:1]};
                  a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
                  b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
                  carry <= cell_cout;
`ifdef SERIAL_ADD_OVF_EN
                  if (cnt == LAST_BIT) begin
                     msb_cin <= carry;
                  end
`endif
                  cnt   <= cnt + CNT_W'(1);
               end
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8). A transaction-level model
// computes results with plain arithmetic and a latency countdown; outputs are
// compared every cycle, and directed tests pin hand-computed values.
// Honours SERIAL_ADD_OVF_EN for the expected ovf values.
module tb_serial_add_ctrl;

   localparam int W = 8;
`ifdef SERIAL_ADD_OVF_EN
   localparam bit OVF_EN = 1'b1;
`else
   localparam bit OVF_EN = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic         op;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;
   logic         ovf;

   int n_pass   = 0;
   int n_checks = 0;

   // model state
   bit           model_valid = 1'b0;
   bit           in_op       = 1'b0;
   int           left        = 0;
   logic         exp_busy    = 1'b0;
   logic         exp_done    = 1'b0;
   logic [W-1:0] exp_sum     = '0;
   logic         exp_cout    = 1'b0;
   logic         exp_ovf     = 1'b0;
   logic [W-1:0] pend_sum;
   logic         pend_cout;
   logic         pend_ovf;

   serial_add_ctrl #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .op    (op),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout),
      .ovf   (ovf)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act === expv) begin
         n_pass++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
      end
   endtask

   // Reference arithmetic: unsigned for sum/cout, signed range test for overflow.
   function automatic void computeModel(input logic opv, input logic [W-1:0] av, input logic [W-1:0] bv,
                                        input logic cinv, output logic [W-1:0] s, output logic c,
                                        output logic v);
      int ua, ub, sa, sb, ur, sr;
      ua = int'(av);
      ub = int'(bv);
      sa = int'($signed(av));
      sb = int'($signed(bv));
      if (opv) begin
         ur = ua - ub;
         sr = sa - sb;
         c  = (ua >= ub);
      end else begin
         ur = ua + ub + int'(cinv);
         sr = sa + sb + int'(cinv);
         c  = (ur > 255);
      end
      s = ur[W-1:0];
      v = OVF_EN && ((sr > 127) || (sr < -128));
   endfunction

   // Transaction model: an accepted start produces its result WIDTH+1 edges later.
   always @(posedge clk) begin
      model_valid = 1'b1;
      if (rst) begin
         in_op    = 1'b0;
         left     = 0;
         exp_busy = 1'b0;
         exp_done = 1'b0;
         exp_sum  = '0;
         exp_cout = 1'b0;
         exp_ovf  = 1'b0;
      end else if (in_op) begin
         left = left - 1;
         if (left == 0) begin
            in_op    = 1'b0;
            exp_done = 1'b1;
            exp_sum  = pend_sum;
            exp_cout = pend_cout;
            exp_ovf  = pend_ovf;
         end
      end else begin
         exp_done = 1'b0;
         if (start) begin
            computeModel(op, a, b, cin, pend_sum, pend_cout, pend_ovf);
            in_op    = 1'b1;
            left     = W + 1;
            exp_busy = 1'b1;
         end else begin
            exp_busy = 1'b0;
         end
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (model_valid) begin
         checkOutput("busy", 32'(busy), 32'(exp_busy));
         checkOutput("done", 32'(done), 32'(exp_done));
         checkOutput("sum",  32'(sum),  32'(exp_sum));
         checkOutput("cout", 32'(cout), 32'(exp_cout));
         checkOutput("ovf",  32'(ovf),  32'(exp_ovf));
      end
   end

   task automatic applyStimulus(input logic opv, input logic [W-1:0] av, input logic [W-1:0] bv, input logic cinv);
      start = 1'b1;
      op    = opv;
      a     = av;
      b     = bv;
      cin   = cinv;
   endtask

   // Call at the negedge where applyStimulus was driven; returns latency in cycles.
   task automatic waitDone(output int lat, output bit busy_dropped);
      lat          = -1;
      busy_dropped = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (i == 1) start = 1'b0;
         if (busy !== 1'b1) busy_dropped = 1'b1;
         if (done === 1'b1) begin
            lat = i - 1;
            break;
         end
      end
   endtask

   task automatic runOp(input string name, input logic opv, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic cinv, input logic [W-1:0] s_exp, input logic c_exp, input logic v_exp);
      int lat;
      bit dropped;
      @(negedge clk);
      applyStimulus(opv, av, bv, cinv);
      waitDone(lat, dropped);
      checkOutput({name, " latency"}, 32'(lat), 32'(9));
      checkOutput({name, " sum"}, 32'(sum), 32'(s_exp));
      checkOutput({name, " cout"}, 32'(cout), 32'(c_exp));
      checkOutput({name, " ovf"}, 32'(ovf), 32'(v_exp));
      @(negedge clk);
      checkOutput({name, " done width"}, 32'(done), 32'(0));
   endtask

   initial begin
      int lat;
      int pulses;
      bit dropped;
      logic [W-1:0] first_sum;

      rst   = 1'b1;
      start = 1'b0;
      op    = 1'b0;
      a     = '0;
      b     = '0;
      cin   = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("reset busy", 32'(busy), 32'(0));
      checkOutput("reset done", 32'(done), 32'(0));
      checkOutput("reset sum",  32'(sum),  32'(0));
      rst = 1'b0;

      runOp("add",      1'b0, 8'h3C, 8'h25, 1'b0, 8'h61, 1'b0, 1'b0);
      runOp("wrap",     1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
      runOp("posovf",   1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, OVF_EN);
      runOp("negovf",   1'b0, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, OVF_EN);
      runOp("addcin",   1'b0, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);
      runOp("sub_neg",  1'b1, 8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0);
      runOp("sub_pos",  1'b1, 8'h20, 8'h10, 1'b0, 8'h10, 1'b1, 1'b0);

      // start during RUN must be ignored
      @(negedge clk);
      applyStimulus(1'b0, 8'h3C, 8'h25, 1'b0);
      pulses    = 0;
      lat       = -1;
      first_sum = '0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (i == 1) start = 1'b0;
         if (i == 3) applyStimulus(1'b0, 8'h01, 8'h01, 1'b0);
         if (i == 4) start = 1'b0;
         if (done === 1'b1) begin
            pulses++;
            if (pulses == 1) begin
               lat       = i - 1;
               first_sum = sum;
            end
         end
      end
      checkOutput("busystart pulses", 32'(pulses), 32'(1));
      checkOutput("busystart latency", 32'(lat), 32'(9));
      checkOutput("busystart sum", 32'(first_sum), 32'(8'h61));
      checkOutput("busystart held", 32'(sum), 32'(8'h61));

      // back-to-back: new start in the DONE cycle
      @(negedge clk);
      applyStimulus(1'b1, 8'h10, 8'h20, 1'b0);
      waitDone(lat, dropped);
      checkOutput("b2b first latency", 32'(lat), 32'(9));
      checkOutput("b2b first sum", 32'(sum), 32'(8'hF0));
      applyStimulus(1'b1, 8'h20, 8'h10, 1'b0);
      waitDone(lat, dropped);
      checkOutput("b2b second latency", 32'(lat), 32'(9));
      checkOutput("b2b busy held", 32'(dropped), 32'(0));
      checkOutput("b2b second sum", 32'(sum), 32'(8'h10));
      checkOutput("b2b second cout", 32'(cout), 32'(1));
      @(negedge clk);

      // reset in the 4th RUN cycle
      @(negedge clk);
      applyStimulus(1'b0, 8'h7F, 8'h01, 1'b0);
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         if (i == 1) start = 1'b0;
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checkOutput("midrst busy", 32'(busy), 32'(0));
      checkOutput("midrst done", 32'(done), 32'(0));
      checkOutput("midrst sum",  32'(sum),  32'(0));
      checkOutput("midrst cout", 32'(cout), 32'(0));
      checkOutput("midrst ovf",  32'(ovf),  32'(0));
      pulses = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (done === 1'b1) pulses++;
      end
      checkOutput("midrst no done", 32'(pulses), 32'(0));
      runOp("postrst", 1'b0, 8'h3C, 8'h25, 1'b0, 8'h61, 1'b0, 1'b0);

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter SHALL be: WIDTH, 8, operand/result width in bits (legal 2..32).
REQ-002 Port `clk` SHALL be: input, 1 bit, sole clock, rising edge.
REQ-003 Port `rst` SHALL be: input, 1 bit, synchronous, active-high reset.
REQ-004 Port `start` SHALL be: input, 1 bit, request a new operation.
REQ-005 Port `op` SHALL be: input, 1 bit, 0 = add, 1 = subtract (a - b); sampled with start.
REQ-006 Ports `a`, `b` SHALL be: inputs, WIDTH bits each, operands; sampled with start.
REQ-007 Port `cin` SHALL be: input, 1 bit, carry-in for add; ignored for subtract.
REQ-008 Port `busy` SHALL be: output, 1 bit, high while an operation is in progress.
REQ-009 Port `done` SHALL be: output, 1 bit, one-cycle pulse when the result becomes valid.
REQ-010 Port `sum` SHALL be: output, WIDTH bits, result.
REQ-011 Port `cout` SHALL be: output, 1 bit, carry out of the MSB.
REQ-012 Port `ovf` SHALL be: output, 1 bit, signed overflow.

Function
REQ-013 The block SHALL compute the result bit-serially through one 1-bit full-adder cell, LSB first, one bit per clock.
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-015 IDLE with start=1 SHALL:
- latch a;
- latch b, or ~b when op=1;
- load the carry register with cin, or with 1 when op=1;
- clear the bit counter;
- go to RUN.
REQ-016 RUN SHALL, each cycle:
- add operand bit 0 of each shift register plus the carry;
- shift the sum bit into the MSB of the result register;
- shift both operand registers right;
- update the carry register;
- increment the counter.
REQ-017 RUN SHALL go to DONE after the cycle that processes bit WIDTH-1.
REQ-018 In DONE, done SHALL be 1 for exactly one cycle, and the state SHALL then return to IDLE.
REQ-019 busy SHALL be 1 in RUN and DONE, and 0 in IDLE.
REQ-020 Latency: with start sampled at edge T, done SHALL be high during the cycle after edge T+WIDTH+1; sum, cout and ovf SHALL be valid from that same cycle.
REQ-021 sum, cout and ovf SHALL hold their values until the next accepted start; they are undefined-free (stable) while RUN is shifting only internally.
REQ-022 sum/cout/ovf SHALL be driven from output registers updated only on the RUN->DONE transition.
REQ-023 start SHALL be ignored while in RUN; no queuing.
REQ-024 start in DONE SHALL be accepted exactly as in IDLE and go directly to RUN (back-to-back operation).
REQ-025 For subtract, cout SHALL be the raw carry, where 1 means no borrow (a >= b unsigned).
REQ-026 ovf SHALL be the carry into the MSB XOR the carry out of the MSB.

Reset
REQ-027 rst=1 at any clock edge, including mid-RUN, SHALL force IDLE.
REQ-028 rst=1 SHALL clear the counter, carry, operand and result registers.
REQ-029 Under reset, busy, done, sum, cout and ovf SHALL all be 0.
REQ-030 rst SHALL take priority over start in the same cycle.

Configuration
REQ-031 With macro SERIAL_ADD_OVF_EN defined, the block SHALL retain the MSB carry-in register, and ovf SHALL follow REQ-026.
REQ-032 Without SERIAL_ADD_OVF_EN, that register SHALL not exist, and ovf SHALL be tied to constant 0.

Structure
REQ-033 A shared package SHALL hold:
- the FSM state enum (IDLE, RUN, DONE);
- the op encoding constants OP_ADD = 0 and OP_SUB = 1.
REQ-034 The 1-bit adder SHALL be a separate sub-module, bit_adder_cell, with inputs a, b, cin and outputs s, cout, instantiated exactly once.
REQ-035 The counter width SHALL be clog2(WIDTH+1).

Verification (WIDTH=8)
REQ-036 Add: a=0x3C, b=0x25, cin=0, op=0 -> sum=0x61, cout=0, ovf=0; done high exactly 9 cycles after the start edge and for exactly one cycle.
REQ-037 Wrap: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0. Also a=0x7F, b=0x01 -> sum=0x80, cout=0, ovf=1 (ovf=0 when SERIAL_ADD_OVF_EN is undefined).
REQ-038 Subtract: a=0x10, b=0x20, op=1, cin=1 (ignored) -> sum=0xF0, cout=0. Also a=0x20, b=0x10 -> sum=0x10, cout=1.
REQ-039 Busy start: a second start with a=0x01, b=0x01 during RUN -> ignored; the first result is unchanged and only one done pulse occurs.
REQ-040 Back-to-back: start during the DONE cycle -> new result delivered 9 cycles later; busy never drops.
REQ-041 Reset mid-op: rst at the 4th RUN cycle -> next cycle state is IDLE with busy=done=sum=cout=ovf=0; no done pulse follows; a subsequent add of 0x3C+0x25 yields 0x61.
